// File: rtl/click_pkg.sv
// Shared types for the click decoder: FSM state and decoded click event.
package click_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        TWO  = 2'd2
    } click_state_t;

    typedef enum logic [1:0] {
        EVT_NONE   = 2'd0,
        EVT_SINGLE = 2'd1,
        EVT_DOUBLE = 2'd2,
        EVT_TRIPLE = 2'd3
    } click_evt_t;

endpackage

// File: rtl/window_timer.sv
// Inter-click window countdown: load WINDOW-1, decrement, saturate at zero.
// zero is combinational from the count register.
module window_timer #(
    parameter int WINDOW = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int CW = $clog2(WINDOW);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(WINDOW - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/click_decoder.sv
// Classifies debounced press pulses into single/double/triple clicks; outputs are
// registered one cycle after the deciding cycle. CLICK_TRIPLE_EN enables the TWO state.
module click_decoder
    import click_pkg::*;
#(
    parameter int WINDOW = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic single_click,
    output logic double_click,
    output logic triple_click,
    output logic busy
);
    click_state_t state_d, state_q;
    click_evt_t   evt_d;
    logic         single_q, double_q, triple_q;
    logic         tmr_load, tmr_dec, tmr_zero;

    window_timer #(.WINDOW(WINDOW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .dec  (tmr_dec),
        .zero (tmr_zero)
    );

    // A pulse always takes priority over an expiring window.
    always_comb begin
        state_d  = state_q;
        evt_d    = EVT_NONE;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d  = ONE;
                    tmr_load = 1'b1;
                end
            end
            ONE: begin
                if (pulse_in) begin
`ifdef CLICK_TRIPLE_EN
                    state_d  = TWO;
                    tmr_load = 1'b1;
`else
                    state_d  = IDLE;
                    evt_d    = EVT_DOUBLE;
`endif
                end else if (tmr_zero) begin
                    state_d = IDLE;
                    evt_d   = EVT_SINGLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
`ifdef CLICK_TRIPLE_EN
            TWO: begin
                if (pulse_in) begin
                    state_d = IDLE;
                    evt_d   = EVT_TRIPLE;
                end else if (tmr_zero) begin
                    state_d = IDLE;
                    evt_d   = EVT_DOUBLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            single_q <= 1'b0;
            double_q <= 1'b0;
            triple_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            single_q <= (evt_d == EVT_SINGLE);
            double_q <= (evt_d == EVT_DOUBLE);
            triple_q <= (evt_d == EVT_TRIPLE);
        end
    end

    assign single_click = single_q;
    assign double_click = double_q;
    assign triple_click = triple_q;
    assign busy         = (state_q != IDLE);

    a_window_min: assert property (@(posedge clk) WINDOW >= 2);

endmodule

// File: tb/tb_click_decoder.sv
// Self-checking bench: directed cycle-exact scenarios plus randomized pulse trains
// checked against a timestamp-based reference model.
module tb_click_decoder;
    localparam int W    = 8;
    localparam int NMAX = 512;
`ifdef CLICK_TRIPLE_EN
    localparam int MAXC = 3;
`else
    localparam int MAXC = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pulse_in = 1'b0;
    logic single_click, double_click, triple_click, busy;

    logic       pin  [NMAX];
    logic       rin  [NMAX];
    logic [3:0] expv [NMAX];   // {single, double, triple, busy}
    logic [3:0] obs  [NMAX];

    int n_vec = 0;
    int n_err = 0;

    click_decoder #(.WINDOW(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pulse_in     (pulse_in),
        .single_click (single_click),
        .double_click (double_click),
        .triple_click (triple_click),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic clear_stim();
        for (int c = 0; c < NMAX; c++) begin
            pin[c]  = 1'b0;
            rin[c]  = 1'b0;
            expv[c] = 4'b0000;
        end
        rin[0] = 1'b1;
    endtask

    task automatic set_busy(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) expv[c][0] = 1'b1;
    endtask

    // Cycle c spans posedge c .. posedge c+1; inputs change just after the edge.
    task automatic run_stim(input int len);
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            pulse_in = pin[c];
            rst      = rin[c];
            @(negedge clk);
            obs[c] = {single_click, double_click, triple_click, busy};
        end
        @(posedge clk);
        #1;
        pulse_in = 1'b0;
        rst      = 1'b0;
    endtask

    // Timestamp model: a click is accepted up to WINDOW cycles after the previous
    // one; the verdict appears the cycle after the window lapses or the final click.
    task automatic model(input int len);
        int cnt;
        int last;
        cnt  = 0;
        last = 0;
        for (int c = 0; c < len; c++) begin
            if (cnt > 0 && c > last + W) begin
                if (cnt == 1) expv[c][3] = 1'b1;
                else          expv[c][2] = 1'b1;
                cnt = 0;
            end
            if (cnt > 0) expv[c][0] = 1'b1;
            if (rin[c]) begin
                cnt = 0;
            end else if (pin[c]) begin
                cnt  = cnt + 1;
                last = c;
                if (cnt == MAXC) begin
                    if (c + 1 < len) expv[c + 1][(MAXC == 3) ? 1 : 2] = 1'b1;
                    cnt = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        clear_stim();
        rin[1] = 1'b1; rin[2] = 1'b1;
        pin[0] = 1'b1; pin[1] = 1'b1; pin[2] = 1'b1;
        run_stim(24);
        for (int c = 1; c < 24; c++) begin
            n_vec++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL reset cycle %0d {s,d,t,busy} got %b want %b", c, obs[c], expv[c]);
            end
        end
    endtask

    task automatic test_single();
        clear_stim();
        pin[10] = 1'b1;
        expv[19][3] = 1'b1;
        set_busy(11, 18);
        run_stim(32);
        for (int c = 1; c < 32; c++) begin
            n_vec++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL single cycle %0d {s,d,t,busy} got %b want %b", c, obs[c], expv[c]);
            end
        end
    endtask

    task automatic test_double();
        clear_stim();
        pin[10] = 1'b1; pin[14] = 1'b1;
`ifdef CLICK_TRIPLE_EN
        expv[23][2] = 1'b1;
        set_busy(11, 22);
`else
        expv[15][2] = 1'b1;
        set_busy(11, 14);
`endif
        run_stim(36);
        for (int c = 1; c < 36; c++) begin
            n_vec++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL double cycle %0d {s,d,t,busy} got %b want %b", c, obs[c], expv[c]);
            end
        end
    endtask

    task automatic test_window_edge();
        clear_stim();
        pin[10] = 1'b1; pin[18] = 1'b1;
`ifdef CLICK_TRIPLE_EN
        expv[27][2] = 1'b1;
        set_busy(11, 26);
`else
        expv[19][2] = 1'b1;
        set_busy(11, 18);
`endif
        run_stim(40);
        for (int c = 1; c < 40; c++) begin
            n_vec++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL edge_in cycle %0d {s,d,t,busy} got %b want %b", c, obs[c], expv[c]);
            end
        end
        clear_stim();
        pin[10] = 1'b1; pin[19] = 1'b1;
        expv[19][3] = 1'b1; expv[28][3] = 1'b1;
        set_busy(11, 18);
        set_busy(20, 27);
        run_stim(40);
        for (int c = 1; c < 40; c++) begin
            n_vec++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL edge_out cycle %0d {s,d,t,busy} got %b want %b", c, obs[c], expv[c]);
            end
        end
    endtask

    task automatic test_reset_mid_sequence();
        clear_stim();
        pin[10] = 1'b1;
        rin[13] = 1'b1;
        set_busy(11, 13);
        run_stim(32);
        for (int c = 1; c < 32; c++) begin
            n_vec++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL rst_mid cycle %0d {s,d,t,busy} got %b want %b", c, obs[c], expv[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_stim();
`ifdef CLICK_TRIPLE_EN
        pin[10] = 1'b1; pin[14] = 1'b1; pin[18] = 1'b1;
        expv[19][1] = 1'b1;
        set_busy(11, 18);
        pin[40] = 1'b1; pin[42] = 1'b1; pin[44] = 1'b1; pin[46] = 1'b1;
        expv[45][1] = 1'b1; expv[55][3] = 1'b1;
        set_busy(41, 44);
        set_busy(47, 54);
`else
        pin[10] = 1'b1; pin[14] = 1'b1; pin[18] = 1'b1;
        expv[15][2] = 1'b1; expv[27][3] = 1'b1;
        set_busy(11, 14);
        set_busy(19, 26);
        pin[40] = 1'b1; pin[41] = 1'b1; pin[42] = 1'b1; pin[43] = 1'b1;
        expv[42][2] = 1'b1; expv[44][2] = 1'b1;
        set_busy(41, 41);
        set_busy(43, 43);
`endif
        run_stim(64);
        for (int c = 1; c < 64; c++) begin
            n_vec++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d {s,d,t,busy} got %b want %b", c, obs[c], expv[c]);
            end
        end
    endtask

    task automatic test_random(input int iters, input int len);
        for (int it = 0; it < iters; it++) begin
            clear_stim();
            for (int c = 1; c < len; c++) begin
                pin[c] = ($urandom_range(0, 4) == 0);
                rin[c] = ($urandom_range(0, 79) == 0);
            end
            model(len);
            run_stim(len);
            for (int c = 1; c < len; c++) begin
                n_vec++;
                if (obs[c] !== expv[c]) begin
                    n_err++;
                    $display("FAIL random%0d cycle %0d {s,d,t,busy} got %b want %b",
                             it, c, obs[c], expv[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_double();
        test_window_edge();
        test_reset_mid_sequence();
        test_back_to_back();
        test_random(4, 400);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/click_decoder.md
CLICK_DECODER -- requirements
Module: click_decoder

Interface
REQ-001 SHALL have parameter WINDOW, default 8, giving the inter-click acceptance window in clk cycles; legal range is 2..65535.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pulse_in  input  1  single-cycle press pulse from the debounce stage (the positive-edge pulse).
REQ-005 SHALL have port single_click  output  1  one-cycle pulse: exactly one press occurred within the window.
REQ-006 SHALL have port double_click  output  1  one-cycle pulse: two presses occurred.
REQ-007 SHALL have port triple_click  output  1  one-cycle pulse: three presses occurred (tied 0 when CLICK_TRIPLE_EN is undefined).
REQ-008 SHALL have port busy  output  1  high while a click sequence is open (state != IDLE).

Function
REQ-009 SHALL implement the states IDLE, ONE and TWO; TWO exists only when CLICK_TRIPLE_EN is defined.
REQ-010 In IDLE, pulse_in SHALL move the block to ONE and load the window counter with WINDOW-1.
REQ-011 In ONE or TWO, with no pulse_in, the counter SHALL decrement by one per cycle.
REQ-012 Timeout is the counter at 0 with no pulse_in that cycle; from ONE it SHALL emit single_click and from TWO it SHALL emit double_click, then return to IDLE.
REQ-013 pulse_in in ONE SHALL move to TWO and reload WINDOW-1 when CLICK_TRIPLE_EN is defined; otherwise it SHALL emit double_click and return to IDLE.
REQ-014 pulse_in in TWO SHALL emit triple_click and return to IDLE.
REQ-015 pulse_in in the same cycle the counter is 0 SHALL count as a click, not a timeout (the click wins).
REQ-016 All outputs SHALL be registered and assert in the cycle after the deciding cycle.
REQ-017 Single-click latency SHALL be exactly WINDOW+1 cycles from the pulse_in cycle.
REQ-018 At most one of single_click, double_click and triple_click SHALL be high in any cycle, each for exactly one cycle per sequence.
REQ-019 pulse_in in the cycle an output pulse is high SHALL be seen in IDLE and SHALL start a new sequence.
REQ-020 Counter width SHALL be $clog2(WINDOW); the counter SHALL never underflow.

Reset
REQ-021 When rst is high at a clk edge, state SHALL be IDLE, the counter 0 and all outputs 0 from the next cycle.
REQ-022 A sequence open at reset SHALL be discarded with no output pulse.
REQ-023 pulse_in coincident with rst SHALL be ignored.

Configuration
REQ-024 Macro CLICK_TRIPLE_EN defined SHALL give the TWO state, triple_click detection, and a full window wait before double_click.
REQ-025 Macro CLICK_TRIPLE_EN undefined SHALL give the ONE state only, with double_click asserted the cycle after the second pulse and triple_click held at 0.

Structure
REQ-026 Package click_pkg SHALL hold the state enum (click_state_t: IDLE, ONE, TWO) and the click-event enum.
REQ-027 The window countdown SHALL be a sub-module window_timer (load, decrement, zero flag), parameterised by WINDOW.
REQ-028 The sim-only assertion WINDOW>=2 SHALL be placed in click_decoder.

Verification (WINDOW=8, pulse cycle numbers)
REQ-029 Pulse at cycle 10 -> single_click high at cycle 19 only; busy high for cycles 11..18.
REQ-030 Pulses at cycles 10 and 14 -> with the macro, double_click at cycle 23; without it, double_click at cycle 15.
REQ-031 With the macro, pulses at cycles 10, 14 and 18 -> triple_click at cycle 19; no other outputs.
REQ-032 Pulses at cycles 10 and 18 -> double sequence (boundary accepted); pulses at cycles 10 and 19 -> single_click at 19 and a second single_click at 28.
REQ-033 Pulse at cycle 10 and rst at cycle 13 -> busy 0 at cycle 14 and no outputs through cycle 30.
REQ-034 With the macro, pulses at cycles 10, 12, 14 and 16 -> triple_click at cycle 15 and single_click at cycle 25.
